// File: rtl/sd_link_arbiter.sv
// sd_link_arbiter
//   Shares the single sen/sd serial link into S2 between two frame sources.
//   Round-robin arbitration picks a requester and captures its frame. The
//   frame is then shifted out MSB first, with sen held low while the frame
//   bits are valid. After each frame, sen stays high for GAP_CYC cycles.
//
// Ports
//   clk, rst             system clock; asynchronous active-high reset
//   req0/frame0          source 0 request and frame (held stable until gnt0)
//   gnt0/done0           source 0 capture pulse / frame-complete pulse
//   req1/frame1          source 1 request and frame
//   gnt1/done1           source 1 capture pulse / frame-complete pulse
//   sen, sd              serial enable (active low) and serial data to S2
//   busy                 high from the grant cycle through the last gap cycle
//   frames_sent          count of completed frames, wraps 255 -> 0
//
// State table
//   state    | meaning
//   ST_IDLE  | link idle, sen=1; arbitrates on every edge
//   ST_SHIFT | frame bits on sd, sen=0; bit_cnt counts down to 0
//   ST_GAP   | sen=1 frame boundary; the last gap edge arbitrates like IDLE
module sd_link_arbiter #(
    parameter int FRAME_W = 21,
    parameter int GAP_CYC = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic [FRAME_W-1:0] frame0,
    output logic               gnt0,
    output logic               done0,
    input  logic               req1,
    input  logic [FRAME_W-1:0] frame1,
    output logic               gnt1,
    output logic               done1,
    output logic               sen,
    output logic               sd,
    output logic               busy,
    output logic [7:0]         frames_sent
);

    localparam int BW = $clog2(FRAME_W);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [BW-1:0] BIT_LOAD = BW'(FRAME_W - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t             state_q, state_d;
    // The MSB goes straight to sd at capture, so only the remaining bits are kept.
    logic [FRAME_W-2:0] shreg_q, shreg_d;
    logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
    // Last source granted; it is also the owner of the frame in flight.
    logic               last_q, last_d;
    logic               sen_q, sen_d;
    logic               sd_q, sd_d;
    logic               gnt0_q, gnt0_d;
    logic               gnt1_q, gnt1_d;
    logic               done0_q, done0_d;
    logic               done1_q, done1_d;
    logic               busy_q, busy_d;
    logic [7:0]         frames_sent_q, frames_sent_d;

    logic               start;
    logic               pick1;
    logic [FRAME_W-1:0] frame_sel;

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        last_d        = last_q;
        sen_d         = sen_q;
        sd_d          = sd_q;
        gnt0_d        = 1'b0;
        gnt1_d        = 1'b0;
        done0_d       = 1'b0;
        done1_d       = 1'b0;
        busy_d        = busy_q;
        frames_sent_d = frames_sent_q;
        start         = 1'b0;

        // On a tie, grant the source that was not granted last.
        pick1     = (req0 && req1) ? ~last_q : req1;
        frame_sel = pick1 ? frame1 : frame0;

        unique case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    start = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q == '0) begin
                    sen_d         = 1'b1;
                    sd_d          = 1'b0;
                    done0_d       = ~last_q;
                    done1_d       = last_q;
                    frames_sent_d = frames_sent_q + 8'd1;
                    gap_cnt_d     = GAP_LOAD;
                    state_d       = ST_GAP;
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                    sd_d      = shreg_q[FRAME_W-2];
                    shreg_d   = {shreg_q[FRAME_W-3:0], 1'b0};
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    if (req0 || req1) begin
                        start = 1'b1;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start) begin
            last_d    = pick1;
            gnt0_d    = ~pick1;
            gnt1_d    = pick1;
            sen_d     = 1'b0;
            sd_d      = frame_sel[FRAME_W-1];
            shreg_d   = frame_sel[FRAME_W-2:0];
            bit_cnt_d = BIT_LOAD;
            busy_d    = 1'b1;
            state_d   = ST_SHIFT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            last_q        <= 1'b1;   // makes the first tie after reset go to src0
            sen_q         <= 1'b1;
            sd_q          <= 1'b0;
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            done0_q       <= 1'b0;
            done1_q       <= 1'b0;
            busy_q        <= 1'b0;
            frames_sent_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            last_q        <= last_d;
            sen_q         <= sen_d;
            sd_q          <= sd_d;
            gnt0_q        <= gnt0_d;
            gnt1_q        <= gnt1_d;
            done0_q       <= done0_d;
            done1_q       <= done1_d;
            busy_q        <= busy_d;
            frames_sent_q <= frames_sent_d;
        end
    end

    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign done0       = done0_q;
    assign done1       = done1_q;
    assign sen         = sen_q;
    assign sd          = sd_q;
    assign busy        = busy_q;
    assign frames_sent = frames_sent_q;

endmodule

// File: tb/tb_sd_link_arbiter.sv
module tb_sd_link_arbiter;

    localparam int FW = 21;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0;
    logic          req1 = 1'b0;
    logic [FW-1:0] frame0 = '0;
    logic [FW-1:0] frame1 = '0;
    logic          gnt0, gnt1, done0, done1, sen, sd, busy;
    logic [7:0]    frames_sent;

    int vectors = 0;
    int miscompares = 0;

    sd_link_arbiter #(.FRAME_W(FW), .GAP_CYC(1)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .frame0(frame0), .gnt0(gnt0), .done0(done0),
        .req1(req1), .frame1(frame1), .gnt1(gnt1), .done1(done1),
        .sen(sen), .sd(sd), .busy(busy), .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] golden(int k);
        logic [2:0]  a;
        logic [17:0] d;
        a = k[2:0];
        d = 18'h15A5A ^ (18'(k) * 18'h00F0F);
        return {a, d};
    endfunction

    task automatic reset_dut();
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({sen, sd, gnt0, gnt1, done0, done1, busy, frames_sent} !== {1'b1, 6'b0, 8'h00}) begin
            $display("FAIL reset_values: got sen=%b sd=%b gnt=%b%b done=%b%b busy=%b fs=%0d expected sen=1 rest 0",
                     sen, sd, gnt0, gnt1, done0, done1, busy, frames_sent);
            miscompares++;
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [FW-1:0] f;
        f = {3'd5, 18'h2AAAA};
        frame0 = f;
        req0   = 1'b1;
        for (int i = 0; i < FW; i++) begin
            @(negedge clk);
            vectors++;
            if (sen !== 1'b0 || sd !== f[FW-1-i]) begin
                $display("FAIL single_bit%0d: got sen=%b sd=%b expected sen=0 sd=%b", i, sen, sd, f[FW-1-i]);
                miscompares++;
            end
            if (i == 0) begin
                vectors++;
                if ({gnt0, gnt1, busy} !== 3'b101) begin
                    $display("FAIL single_grant: got gnt0=%b gnt1=%b busy=%b expected 1 0 1", gnt0, gnt1, busy);
                    miscompares++;
                end
                req0   = 1'b0;
                frame0 = '0;
            end
        end
        @(negedge clk);
        vectors++;
        if ({sen, sd, done0, done1, frames_sent} !== {4'b1010, 8'd1}) begin
            $display("FAIL single_done: got sen=%b sd=%b done0=%b done1=%b fs=%0d expected 1 0 1 0 1",
                     sen, sd, done0, done1, frames_sent);
            miscompares++;
        end
        @(negedge clk);
        vectors++;
        if ({busy, sen, done0, gnt0} !== 4'b0100) begin
            $display("FAIL single_idle: got busy=%b sen=%b done0=%b gnt0=%b expected 0 1 0 0", busy, sen, done0, gnt0);
            miscompares++;
        end
    endtask

    task automatic test_tie();
        logic [FW-1:0] fa, fb;
        fa = {3'd2, 18'h3F00F};
        fb = {3'd6, 18'h0C3A5};
        reset_dut();
        frame0 = fa;
        frame1 = fb;
        req0 = 1'b1;
        req1 = 1'b1;
        for (int i = 0; i < FW; i++) begin
            @(negedge clk);
            vectors++;
            if (sen !== 1'b0 || sd !== fa[FW-1-i] || gnt1 !== 1'b0) begin
                $display("FAIL tie_src0_bit%0d: got sen=%b sd=%b gnt1=%b expected sen=0 sd=%b gnt1=0",
                         i, sen, sd, gnt1, fa[FW-1-i]);
                miscompares++;
            end
            if (i == 0) begin
                vectors++;
                if (gnt0 !== 1'b1) begin
                    $display("FAIL tie_gnt0: got %b expected 1", gnt0);
                    miscompares++;
                end
                req0 = 1'b0;
            end
        end
        @(negedge clk);
        vectors++;
        if ({sen, sd, done0, gnt1} !== 4'b1010) begin
            $display("FAIL tie_done0: got sen=%b sd=%b done0=%b gnt1=%b expected 1 0 1 0", sen, sd, done0, gnt1);
            miscompares++;
        end
        for (int i = 0; i < FW; i++) begin
            @(negedge clk);
            vectors++;
            if (sen !== 1'b0 || sd !== fb[FW-1-i]) begin
                $display("FAIL tie_src1_bit%0d: got sen=%b sd=%b expected sen=0 sd=%b", i, sen, sd, fb[FW-1-i]);
                miscompares++;
            end
            if (i == 0) begin
                vectors++;
                if ({gnt0, gnt1, busy} !== 3'b011) begin
                    $display("FAIL tie_gnt1: got gnt0=%b gnt1=%b busy=%b expected 0 1 1", gnt0, gnt1, busy);
                    miscompares++;
                end
                req1 = 1'b0;
            end
        end
        @(negedge clk);
        vectors++;
        if ({done0, done1, frames_sent} !== {2'b01, 8'd2}) begin
            $display("FAIL tie_done1: got done0=%b done1=%b fs=%0d expected 0 1 2", done0, done1, frames_sent);
            miscompares++;
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            $display("FAIL tie_idle_busy: got %b expected 0", busy);
            miscompares++;
        end
    endtask

    task automatic test_saturation();
        logic [FW-1:0] got;
        logic          sen_bad;
        reset_dut();
        frame0 = golden(0);
        frame1 = golden(1);
        req0 = 1'b1;
        req1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            got     = '0;
            sen_bad = 1'b0;
            for (int i = 0; i < FW; i++) begin
                @(negedge clk);
                got = {got[FW-2:0], sd};
                if (sen !== 1'b0) sen_bad = 1'b1;
                if (i == 0) begin
                    vectors++;
                    if ({gnt0, gnt1} !== ((k % 2 == 1) ? 2'b01 : 2'b10)) begin
                        $display("FAIL sat_grant_order k=%0d: got gnt0=%b gnt1=%b", k, gnt0, gnt1);
                        miscompares++;
                    end
                    if (k % 2 == 0) begin
                        frame0 = golden(k + 2);
                        if (k + 2 > 7) req0 = 1'b0;
                    end else begin
                        frame1 = golden(k + 2);
                        if (k + 2 > 7) req1 = 1'b0;
                    end
                end
            end
            vectors++;
            if (got !== golden(k) || sen_bad) begin
                $display("FAIL sat_frame k=%0d: got %h sen_bad=%b expected %h", k, got, sen_bad, golden(k));
                miscompares++;
            end
            @(negedge clk);
            vectors++;
            if ({sen, sd, done0, done1} !== {2'b10, (k % 2 == 0), (k % 2 == 1)}) begin
                $display("FAIL sat_done k=%0d: got sen=%b sd=%b done0=%b done1=%b", k, sen, sd, done0, done1);
                miscompares++;
            end
        end
        @(negedge clk);
        vectors++;
        if ({busy, frames_sent} !== {1'b0, 8'd8}) begin
            $display("FAIL sat_end: got busy=%b fs=%0d expected 0 8", busy, frames_sent);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid();
        logic [FW-1:0] fa, fb;
        fa = {3'd3, 18'h1B4E2};
        fb = {3'd4, 18'h2D1C7};
        reset_dut();
        frame0 = fa;
        frame1 = fb;
        req0 = 1'b1;
        req1 = 1'b1;
        repeat (11) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({sen, sd, busy, done0, frames_sent} !== {4'b1000, 8'd0}) begin
            $display("FAIL rstmid_async: got sen=%b sd=%b busy=%b done0=%b fs=%0d expected 1 0 0 0 0",
                     sen, sd, busy, done0, frames_sent);
            miscompares++;
        end
        repeat (2) @(negedge clk);
        vectors++;
        if ({sen, sd, gnt0, gnt1, done0, done1, busy} !== 7'b1000000) begin
            $display("FAIL rstmid_held: got sen=%b sd=%b gnt=%b%b done=%b%b busy=%b expected 1 0 00 00 0",
                     sen, sd, gnt0, gnt1, done0, done1, busy);
            miscompares++;
        end
        rst = 1'b0;
        for (int i = 0; i < FW; i++) begin
            @(negedge clk);
            vectors++;
            if (sen !== 1'b0 || sd !== fa[FW-1-i]) begin
                $display("FAIL rstmid_bit%0d: got sen=%b sd=%b expected sen=0 sd=%b", i, sen, sd, fa[FW-1-i]);
                miscompares++;
            end
            if (i == 0) begin
                vectors++;
                if ({gnt0, gnt1} !== 2'b10) begin
                    $display("FAIL rstmid_tie: got gnt0=%b gnt1=%b expected 1 0", gnt0, gnt1);
                    miscompares++;
                end
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        @(negedge clk);
        vectors++;
        if ({done0, frames_sent} !== {1'b1, 8'd1}) begin
            $display("FAIL rstmid_done: got done0=%b fs=%0d expected 1 1", done0, frames_sent);
            miscompares++;
        end
        @(negedge clk);
    endtask

    task automatic test_withdrawal();
        int gnt1_seen;
        int done0_seen;
        gnt1_seen  = 0;
        done0_seen = 0;
        frame0 = {3'd7, 18'h00FF0};
        frame1 = {3'd1, 18'h3FFFF};
        req0 = 1'b1;
        for (int i = 0; i < FW + 4; i++) begin
            @(negedge clk);
            if (gnt1) gnt1_seen++;
            if (done0) done0_seen++;
            if (i == 0) req0 = 1'b0;
            if (i == 5) req1 = 1'b1;
            if (i == 8) req1 = 1'b0;
        end
        vectors++;
        if (gnt1_seen != 0 || done0_seen != 1) begin
            $display("FAIL withdraw_gnt1: got gnt1 pulses=%0d done0 pulses=%0d expected 0 1", gnt1_seen, done0_seen);
            miscompares++;
        end
        vectors++;
        if ({busy, sen, frames_sent} !== {2'b01, 8'd2}) begin
            $display("FAIL withdraw_idle: got busy=%b sen=%b fs=%0d expected 0 1 2", busy, sen, frames_sent);
            miscompares++;
        end
    endtask

    task automatic test_wrap();
        logic got_done;
        reset_dut();
        frame0 = {3'd0, 18'h12345};
        req0 = 1'b1;
        for (int n = 0; n < 256; n++) begin
            got_done = 1'b0;
            for (int t = 0; t < 40 && !got_done; t++) begin
                @(negedge clk);
                if (gnt0 && n == 255) req0 = 1'b0;
                if (done0) got_done = 1'b1;
            end
            vectors++;
            if (!got_done) begin
                $display("FAIL wrap_timeout n=%0d: got no done0 within 40 cycles expected done0", n);
                miscompares++;
                req0 = 1'b0;
                break;
            end else if (frames_sent !== 8'(n + 1)) begin
                $display("FAIL wrap_count n=%0d: got %0d expected %0d", n, frames_sent, 8'(n + 1));
                miscompares++;
            end
        end
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, frames_sent} !== {1'b0, 8'h00}) begin
            $display("FAIL wrap_end: got busy=%b fs=%0d expected 0 0", busy, frames_sent);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_saturation();
        test_reset_mid();
        test_withdrawal();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
